instruction_fetch: RTL
======================

# instruction_fetch

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. It drives the decode stage's instruction input (`Instruction1`) and consumes the decode stage's stall (`PCWrite`, `IFIDWrite`) and redirect (`PCSrc`, `J_JR_Branch_signal`) outputs. It holds the PC, computes the next PC (sequential, branch, jump, or register jump), and presents the instruction-memory address. It inserts bubbles on stall and flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_WORD`, default 32'h0000_0000: instruction word used for a bubble (`sll $0,$0,0`).

- `Clk`  in  1  rising-edge clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `PCWrite`  in  1  1 = PC may update; 0 = PC holds (load-use stall).
- `IFIDWrite`  in  1  1 = IF/ID register may load; 0 = IF/ID holds.
- `PCSrc`  in  1  redirect request from decode, for the instruction currently in IF/ID.
- `J_JR_Branch_signal`  in  2  redirect kind: 00 branch, 01 j/jal, 10 jr/jalr, 11 none.
- `BranchTarget`  in  32  branch target computed in decode.
- `JumpRegTarget`  in  32  register target for jr (forwarded rs value).
- `imem_rdata`  in  32  instruction word at `imem_addr`; combinational, same cycle.
- `imem_addr`  out  32  current PC, word-aligned.
- `Instruction1`  out  32  IF/ID instruction.
- `PCAddResult_out`  out  32  IF/ID PC+4.
- `IFIDValid`  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.

## Operation
- PC register `pc`. `imem_addr = pc` with bits [1:0] forced to 0. `pc_plus4 = pc + 4`, a 32-bit wrap.
- A redirect is taken when `PCSrc=1`, `PCWrite=1`, and `J_JR_Branch_signal != 11`.
- Redirect targets:
  - 00: `BranchTarget`.
  - 01: `{PCAddResult_out[31:28], Instruction1[25:0], 2'b00}`.
  - 10: `{JumpRegTarget[31:2], 2'b00}`.
- Next-PC priority:
  1. `Reset` → `RESET_PC`.
  2. `PCWrite=0` → hold. Any redirect is ignored; decode re-asserts it after the stall.
  3. Redirect taken → target.
  4. Otherwise → `pc_plus4`.
- IF/ID update priority:
  1. `Reset` → `Instruction1=NOP_WORD`, `PCAddResult_out=0`, `IFIDValid=0`.
  2. Flush (redirect taken, delay slot disabled) → `NOP_WORD`, `PC+4 = pc_plus4`, `IFIDValid=0`. Flush overrides `IFIDWrite`.
  3. `IFIDWrite=0` → hold all three fields.
  4. Otherwise → `imem_rdata`, `pc_plus4`, `IFIDValid=1`.
- Effective states of the IF/ID slot:
  - RESET → FETCH on the first clock after `Reset` deasserts.
  - FETCH → STALL while `PCWrite=0`. STALL → FETCH when it returns to 1.
  - FETCH → FLUSH on a taken redirect, for one cycle. FLUSH → FETCH.
- `Reset` asserted mid-operation discards any pending redirect or stall in that cycle.

## Timing
- Single-cycle fetch: the instruction at PC p appears on `Instruction1` one clock after `pc = p`.
- Redirect resolves in decode and is sampled at the edge. The target is fetched the next cycle, so the penalty is one bubble, or zero with the delay slot enabled.
- Stall: PC and IF/ID are frozen on the same edge, with no extra latency. The same instruction is re-presented to decode until release.
- Reset values:
  - `imem_addr = RESET_PC`
  - `Instruction1 = NOP_WORD`
  - `PCAddResult_out = 0`
  - `IFIDValid = 0`
- The first valid instruction appears on `Instruction1` one clock after `Reset` falls.
- Boundary conditions:
  - PC wraps from 32'hFFFF_FFFC to 0.
  - A redirect to the current PC is legal (tight loop).
  - `PCSrc=1` with `J_JR_Branch_signal=11` is treated as no redirect.

## Configuration
- `IF_DELAY_SLOT_EN` defined: MIPS branch delay slot. The instruction fetched in the redirect cycle is loaded into IF/ID normally (`IFIDValid=1`), and no flush occurs.
- `IF_DELAY_SLOT_EN` undefined (default): a taken redirect flushes IF/ID to `NOP_WORD`, `IFIDValid=0`.

## Test plan
- **Reset then fetch:** hold `Reset` for 2 cycles, memory returns addr×0x10.
  - `imem_addr` sequence 0, 4, 8.
  - `Instruction1` = 0x0 one cycle after reset falls, then 0x40, then 0x80.
  - `IFIDValid` rises one cycle after reset falls.
- **Load-use stall:** `PCWrite=IFIDWrite=0` for 1 cycle at PC 0x10.
  - `imem_addr` stays 0x10 for 2 cycles.
  - `Instruction1` (from 0xC) is held for 2 cycles.
- **Branch with flush:** `PCSrc=1`, kind 00, `BranchTarget=0x100` while IF/ID holds the 0x8 instruction.
  - Next cycle: `imem_addr=0x100`, `Instruction1=NOP_WORD`, `IFIDValid=0`.
  - With `IF_DELAY_SLOT_EN`: `Instruction1` = word at 0xC, `IFIDValid=1`.
- **Jump and jr:**
  - j with `Instruction1[25:0]=0x40` and `PCAddResult_out=0x1000_0008` → `imem_addr=0x1000_0100`.
  - jr with `JumpRegTarget=0x203` → `imem_addr=0x200`.
- **Stall plus redirect in the same cycle:** `PCWrite=0`, `PCSrc=1` → PC holds and no flush.
  - Next cycle `PCWrite=1`, `PCSrc=1` → redirect taken.
- **Reset mid-operation and wrap:**
  - `Reset` together with `PCSrc=1` → `imem_addr=RESET_PC`, IF/ID = `NOP_WORD`.
  - Force PC 0xFFFF_FFFC → next `imem_addr=0`.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS instruction-fetch stage with IF/ID pipeline register (optional IF_DELAY_SLOT_EN)

module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        PCSrc,
   input  logic [1:0]  J_JR_Branch_signal,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] JumpRegTarget,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] Instruction1,
   output logic [31:0] PCAddResult_out,
   output logic        IFIDValid
);

   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JUMP   = 2'b01;
   localparam logic [1:0] KIND_JREG   = 2'b10;
   localparam logic [1:0] KIND_NONE   = 2'b11;

   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [31:0] jumpTarget;
   logic [31:0] jumpRegAligned;
   logic [31:0] redirectTarget;
   logic        redirectTaken;
   logic        flush;

   logic [31:0] instrReg;
   logic [31:0] pcPlus4Reg;
   logic        validReg;

   assign pcPlus4   = pc + 32'd4;
   assign imem_addr = {pc[31:2], 2'b00};

   // Jump targets are formed from the instruction already sitting in IF/ID.
   assign jumpTarget     = {pcPlus4Reg[31:28], instrReg[25:0], 2'b00};
   assign jumpRegAligned = JumpRegTarget & 32'hFFFF_FFFC;

   // A redirect requested during a stall is dropped; decode re-asserts it afterwards.
   assign redirectTaken = PCSrc && PCWrite && (J_JR_Branch_signal != KIND_NONE);

`ifdef IF_DELAY_SLOT_EN
   // The instruction fetched alongside the redirect is the delay slot and must execute.
   assign flush = 1'b0;
`else
   assign flush = redirectTaken;
`endif

   // Select the redirect destination by kind.
   always_comb begin
      redirectTarget = pcPlus4;
      case (J_JR_Branch_signal)
         KIND_BRANCH: redirectTarget = BranchTarget;
         KIND_JUMP:   redirectTarget = jumpTarget;
         KIND_JREG:   redirectTarget = jumpRegAligned;
         default:     redirectTarget = pcPlus4;
      endcase
   end

   // PC register: reset, stall hold, redirect, or sequential advance.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc <= RESET_PC;
      end else if (!PCWrite) begin
         pc <= pc;
      end else if (redirectTaken) begin
         pc <= redirectTarget;
      end else begin
         pc <= pcPlus4;
      end
   end

   // IF/ID register: flush beats the IF/ID write enable so a stale fetch never reaches decode.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         instrReg   <= NOP_WORD;
         pcPlus4Reg <= 32'h0000_0000;
         validReg   <= 1'b0;
      end else if (flush) begin
         instrReg   <= NOP_WORD;
         pcPlus4Reg <= pcPlus4;
         validReg   <= 1'b0;
      end else if (IFIDWrite) begin
         instrReg   <= imem_rdata;
         pcPlus4Reg <= pcPlus4;
         validReg   <= 1'b1;
      end
   end

   assign Instruction1    = instrReg;
   assign PCAddResult_out = pcPlus4Reg;
   assign IFIDValid       = validReg;

endmodule
